// File: rtl/ppt_pkg.sv
// Shared definitions for the multi-channel pulse-train engine: register map,
// CTRL/STATUS bit positions and the per-channel state encoding.
package ppt_pkg;
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_DIV    = 3'd1;
  localparam logic [2:0] OFF_PER_LO = 3'd2;
  localparam logic [2:0] OFF_PER_HI = 3'd3;
  localparam logic [2:0] OFF_WID_LO = 3'd4;
  localparam logic [2:0] OFF_WID_HI = 3'd5;
  localparam logic [2:0] OFF_COUNT  = 3'd6;
  localparam logic [2:0] OFF_STATUS = 3'd7;

  localparam logic [7:0] ADDR_SYNC     = 8'hF0;
  localparam logic [7:0] ADDR_IRQ_STAT = 8'hF1;

  localparam int CTRL_RUN  = 0;
  localparam int CTRL_CONT = 1;
  localparam int CTRL_POL  = 2;
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} ch_state_t;

  function automatic logic [3:0] clamp_div(input logic [4:0] d);
    return d[4] ? 4'hF : d[3:0];
  endfunction
endpackage

// File: rtl/ppt_channel.sv
// One pulse-train channel: register file, shadow copies, prescaler,
// IDLE/ACTIVE/DONE sequencer and the registered pulse output.
module ppt_channel
  import ppt_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int PCNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic       sync,
  input  logic [2:0] raddr,
  output logic [7:0] rdata,
  output logic       pulse_out,
  output logic       busy,
  output logic       done,
  output logic       done_evt
);
  logic [2:0]        ctrl_r;
  logic [4:0]        div_r;
  logic [CNT_W-1:0]  per_r, wid_r, per_sh, wid_sh, phase;
  logic [PCNT_W-1:0] cnt_r, cnt_sh, pcnt;
  logic [3:0]        div_sh;
  logic [14:0]       presc;
  logic              err_r;
  ch_state_t         state;

  logic        ctrl_wr, start, abort, per_ok, burst, start_burst;
  logic        tick, wrap, last, zero_burst, act_nxt, pol_nxt;
  logic [15:0] presc_lim, per16, wid16;

  assign ctrl_wr     = we && (waddr == OFF_CTRL);
  assign start       = (ctrl_wr && wdata[CTRL_RUN]) || (sync && ctrl_r[CTRL_RUN] && !ctrl_wr);
  assign abort       = ctrl_wr && !wdata[CTRL_RUN];
  assign per_ok      = (per_r != '0);
  assign burst       = !ctrl_r[CTRL_CONT];
  assign start_burst = ctrl_wr ? !wdata[CTRL_CONT] : !ctrl_r[CTRL_CONT];
  assign pol_nxt     = ctrl_wr ? wdata[CTRL_POL] : ctrl_r[CTRL_POL];

  assign presc_lim  = (16'd1 << div_sh) - 16'd1;
  assign tick       = ({1'b0, presc} == presc_lim);
  assign wrap       = tick && (phase == per_sh - CNT_W'(1));
  assign last       = burst && (pcnt + PCNT_W'(1) == cnt_sh);
  assign zero_burst = burst && (cnt_sh == '0);

  // Active level as it will be after this edge, so pulse_out leads nothing.
  always_comb begin
    act_nxt = 1'b0;
    if (start)
      act_nxt = per_ok && (wid_r != '0) && !(start_burst && cnt_r == '0);
    else if (!abort && state == ST_ACTIVE && !zero_burst) begin
      if (wrap)      act_nxt = !last && (wid_r != '0);
      else if (tick) act_nxt = (phase + CNT_W'(1)) < wid_sh;
      else           act_nxt = phase < wid_sh;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_r <= '0; div_r <= '0; per_r <= '0; wid_r <= '0; cnt_r <= '0;
      per_sh <= '0; wid_sh <= '0; cnt_sh <= '0; div_sh <= '0;
      presc <= '0; phase <= '0; pcnt <= '0; err_r <= 1'b0;
      state <= ST_IDLE; pulse_out <= 1'b0; done_evt <= 1'b0;
    end else begin
      done_evt <= 1'b0;
      if (we) begin
        case (waddr)
          OFF_CTRL:   ctrl_r <= wdata[2:0];
          OFF_DIV:    div_r <= wdata[4:0];
          OFF_PER_LO: per_r[7:0] <= wdata;
          OFF_PER_HI: per_r[CNT_W-1:8] <= wdata[CNT_W-9:0];
          OFF_WID_LO: wid_r[7:0] <= wdata;
          OFF_WID_HI: wid_r[CNT_W-1:8] <= wdata[CNT_W-9:0];
          OFF_COUNT:  cnt_r <= wdata[PCNT_W-1:0];
          default: ;
        endcase
      end
      if (start) begin
        if (!per_ok) begin
          err_r <= 1'b1;
          state <= ST_IDLE;
        end else begin
          err_r  <= 1'b0;
          per_sh <= per_r;
          wid_sh <= wid_r;
          cnt_sh <= cnt_r;
          div_sh <= clamp_div(div_r);
          presc  <= '0;
          phase  <= '0;
          pcnt   <= '0;
          state  <= ST_ACTIVE;
        end
      end else if (abort) begin
        state <= ST_IDLE;
      end else if (state == ST_ACTIVE) begin
        if (zero_burst) begin
          state    <= ST_DONE;
          done_evt <= 1'b1;
        end else if (tick) begin
          presc <= '0;
          if (wrap) begin
            // Pick up live settings only here so a pulse is never cut short;
            // a zero period is not adopted since it would never wrap.
            phase  <= '0;
            pcnt   <= pcnt + PCNT_W'(1);
            wid_sh <= wid_r;
            div_sh <= clamp_div(div_r);
            if (per_ok) per_sh <= per_r;
            if (last) begin
              state    <= ST_DONE;
              done_evt <= 1'b1;
            end
          end else begin
            phase <= phase + CNT_W'(1);
          end
        end else begin
          presc <= presc + 15'd1;
        end
      end
      pulse_out <= act_nxt ^ pol_nxt;
    end
  end

  assign busy  = (state == ST_ACTIVE);
  assign done  = (state == ST_DONE);
  assign per16 = 16'(per_r);
  assign wid16 = 16'(wid_r);

  always_comb begin
    rdata = '0;
    case (raddr)
      OFF_CTRL:   rdata = {5'd0, ctrl_r};
      OFF_DIV:    rdata = {3'd0, div_r};
      OFF_PER_LO: rdata = per16[7:0];
      OFF_PER_HI: rdata = per16[15:8];
      OFF_WID_LO: rdata = wid16[7:0];
      OFF_WID_HI: rdata = wid16[15:8];
      OFF_COUNT:  rdata = 8'(cnt_r);
      OFF_STATUS: rdata = {5'd0, err_r, done, busy};
      default: ;
    endcase
  end
endmodule

// File: rtl/multi_ppt_engine.sv
// Multi-channel pulse-train engine top: address decode, read mux, SYNC start
// and optional interrupt status (enabled by defining PPT_IRQ_EN).
module multi_ppt_engine
  import ppt_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        reg_addr,
  input  logic [7:0]        reg_wdata,
  input  logic              reg_we,
  output logic [7:0]        reg_rdata,
  output logic [NUM_CH-1:0] pulse_out,
  output logic [NUM_CH-1:0] busy,
`ifdef PPT_IRQ_EN
  output logic              irq,
`endif
  output logic [NUM_CH-1:0] done
);
  logic [NUM_CH-1:0]      sel, sync_vec, done_evt;
  logic [NUM_CH-1:0][7:0] ch_rdata;

  // SYNC is a byte register, so only channels 0..7 can be group-started.
  assign sync_vec = (reg_we && reg_addr == ADDR_SYNC) ? NUM_CH'(reg_wdata) : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign sel[g] = (reg_addr[7:3] == 5'(g));
    ppt_channel #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .we        (reg_we & sel[g]),
      .waddr     (reg_addr[2:0]),
      .wdata     (reg_wdata),
      .sync      (sync_vec[g]),
      .raddr     (reg_addr[2:0]),
      .rdata     (ch_rdata[g]),
      .pulse_out (pulse_out[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .done_evt  (done_evt[g])
    );
  end

`ifdef PPT_IRQ_EN
  logic [NUM_CH-1:0] irq_stat, irq_clr;

  assign irq_clr = (reg_we && reg_addr == ADDR_IRQ_STAT) ? NUM_CH'(reg_wdata) : '0;

  // A completion landing with a clear of the same bit keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) irq_stat <= '0;
    else     irq_stat <= (irq_stat & ~irq_clr) | done_evt;
  end

  assign irq = |irq_stat;
`else
  logic unused_done_evt;
  assign unused_done_evt = ^done_evt;
`endif

  always_comb begin
    reg_rdata = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (sel[i]) reg_rdata = ch_rdata[i];
`ifdef PPT_IRQ_EN
    if (reg_addr == ADDR_IRQ_STAT) reg_rdata = 8'(irq_stat);
`endif
  end
endmodule

// File: tb/tb_multi_ppt_engine.sv
// Directed self-checking bench for multi_ppt_engine (default NUM_CH=4).
module tb_multi_ppt_engine;
  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        reg_addr, reg_wdata, reg_rdata;
  logic              reg_we;
  logic [NUM_CH-1:0] pulse_out, busy, done;
`ifdef PPT_IRQ_EN
  logic              irq;
`endif
  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multi_ppt_engine #(.NUM_CH(NUM_CH), .CNT_W(16), .PCNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_rdata (reg_rdata),
    .pulse_out (pulse_out),
    .busy      (busy),
`ifdef PPT_IRQ_EN
    .irq       (irq),
`endif
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_addr = a; reg_wdata = d; reg_we = 1'b1;
    @(posedge clk); #1;
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    reg_addr = a; #1;
    d = reg_rdata;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic [7:0] d;
  logic       prev, a1;
  int         act, act2, rises, mis;

  initial begin
    rst = 1'b1; reg_addr = '0; reg_wdata = '0; reg_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pulse", 32'(pulse_out), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    rd(8'h02, d); chk("rst_period", 32'(d), 0);
    @(negedge clk); rst = 1'b0;

    // register map: readback, unmapped, write-only SYNC, polarity in IDLE
    wr(8'd19, 8'hA5); rd(8'd19, d); chk("rb_per_hi", 32'(d), 32'hA5);
    wr(8'd19, 8'h00);
    wr(8'h40, 8'h55); rd(8'h40, d); chk("unmapped", 32'(d), 0);
    wr(8'hF0, 8'h00); rd(8'hF0, d); chk("sync_rd", 32'(d), 0);
`ifndef PPT_IRQ_EN
    wr(8'hF1, 8'hFF); rd(8'hF1, d); chk("irq_stat_absent", 32'(d), 0);
`endif
    wr(8'd8, 8'h04); chk("idle_pol", 32'(pulse_out[1]), 1);
    wr(8'd8, 8'h00); chk("idle_nopol", 32'(pulse_out[1]), 0);

    // burst: 4 pulses of 3 clk in 10 clk periods, DONE after 40 clk
    wr(8'd2, 8'd10); wr(8'd4, 8'd3); wr(8'd6, 8'd4); wr(8'd0, 8'h01);
    act = 0; rises = 0; prev = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      if (pulse_out[0]) act++;
      if (pulse_out[0] && !prev) rises++;
      prev = pulse_out[0];
      if (k == 3) chk("burst_k3", 32'(pulse_out[0]), 1);
      if (k == 4) chk("burst_k4", 32'(pulse_out[0]), 0);
      if (k == 40) begin
        chk("burst_k40_done", 32'(done[0]), 0);
        chk("burst_k40_busy", 32'(busy[0]), 1);
      end
      if (k == 41) begin
        chk("burst_k41_done", 32'(done[0]), 1);
        chk("burst_k41_busy", 32'(busy[0]), 0);
      end
      step();
    end
    chk("burst_active", act, 12);
    chk("burst_pulses", rises, 4);

    // continuous, DIV=2: 8 clk active of every 20, then abort
    wr(8'd9, 8'd2); wr(8'd10, 8'd5); wr(8'd12, 8'd2); wr(8'd8, 8'h03);
    mis = 0;
    for (int k = 1; k <= 60; k++) begin
      if (pulse_out[1] !== (((k - 1) % 20) < 8)) mis++;
      step();
    end
    chk("cont_pattern", mis, 0);
    chk("cont_busy", 32'(busy[1]), 1);
    chk("cont_pre_abort", 32'(pulse_out[1]), 1);
    wr(8'd8, 8'h00);
    chk("abort_pulse", 32'(pulse_out[1]), 0);
    chk("abort_done",  32'(done[1]), 0);
    chk("abort_busy",  32'(busy[1]), 0);

    // SYNC start of ch0 and ch2 with equal settings
    wr(8'd2, 8'd6); wr(8'd4, 8'd1); wr(8'd0, 8'h03);
    wr(8'd18, 8'd6); wr(8'd20, 8'd1); wr(8'd16, 8'h03);
    wr(8'hF0, 8'h05);
    mis = 0; act = 0; act2 = 0;
    for (int k = 1; k <= 30; k++) begin
      if (pulse_out[0] !== pulse_out[2]) mis++;
      if (pulse_out[0]) act++;
      if (pulse_out[2]) act2++;
      if (k == 1) chk("sync_k1", 32'(pulse_out[0]), 1);
      if (k == 2) chk("sync_k2", 32'(pulse_out[0]), 0);
      step();
    end
    chk("sync_align", mis, 0);
    chk("sync_act0", act, 5);
    chk("sync_act2", act2, 5);
    wr(8'd0, 8'h00); wr(8'd16, 8'h00);

    // WIDTH=0: no pulses, DONE after COUNT periods
    wr(8'd26, 8'd3); wr(8'd28, 8'd0); wr(8'd30, 8'd2); wr(8'd24, 8'h01);
    act = 0;
    for (int k = 1; k <= 8; k++) begin
      if (pulse_out[3]) act++;
      if (k == 6) begin
        chk("w0_k6_done", 32'(done[3]), 0);
        chk("w0_k6_busy", 32'(busy[3]), 1);
      end
      if (k == 7) chk("w0_k7_done", 32'(done[3]), 1);
      step();
    end
    chk("w0_active", act, 0);

    // WIDTH=PERIOD: constant active level
    wr(8'd26, 8'd7); wr(8'd28, 8'd7); wr(8'd24, 8'h03);
    act = 0;
    for (int k = 1; k <= 20; k++) begin
      if (pulse_out[3]) act++;
      step();
    end
    chk("wfull_active", act, 20);
    wr(8'd24, 8'h00);

    // PERIOD=0: err, stays IDLE
    wr(8'd26, 8'd0); wr(8'd24, 8'h01);
    chk("p0_busy", 32'(busy[3]), 0);
    chk("p0_pulse", 32'(pulse_out[3]), 0);
    rd(8'd31, d); chk("p0_status", 32'(d), 32'h4);

    // COUNT=0: one ACTIVE cycle without a pulse, then DONE; err cleared
    wr(8'd26, 8'd4); wr(8'd28, 8'd2); wr(8'd30, 8'd0); wr(8'd24, 8'h01);
    chk("c0_k1_busy", 32'(busy[3]), 1);
    chk("c0_k1_pulse", 32'(pulse_out[3]), 0);
    rd(8'd31, d); chk("c0_k1_status", 32'(d), 32'h1);
    step();
    chk("c0_k2_done", 32'(done[3]), 1);
    chk("c0_k2_pulse", 32'(pulse_out[3]), 0);
    rd(8'd31, d); chk("c0_k2_status", 32'(d), 32'h2);

    // WIDTH 3->5 mid-pulse: current pulse keeps 3, next is 5
    wr(8'd2, 8'd10); wr(8'd4, 8'd3); wr(8'd6, 8'd3); wr(8'd0, 8'h01);
    a1 = pulse_out[0];
    wr(8'd4, 8'd5);
    act = a1 ? 1 : 0; act2 = 0;
    for (int k = 2; k <= 20; k++) begin
      if (pulse_out[0]) begin
        if (k <= 10) act++;
        else act2++;
      end
      step();
    end
    chk("wchg_first", act, 3);
    chk("wchg_second", act2, 5);

`ifdef PPT_IRQ_EN
    wr(8'hF1, 8'hFF);
    rd(8'hF1, d); chk("irq_cleared0", 32'(d), 0);
    wr(8'd2, 8'd2); wr(8'd4, 8'd1); wr(8'd6, 8'd1); wr(8'd0, 8'h01);
    repeat (3) step();
    rd(8'hF1, d); chk("irq_stat_set", 32'(d), 32'h1);
    chk("irq_set", 32'(irq), 1);
    wr(8'hF1, 8'h01);
    rd(8'hF1, d); chk("irq_stat_clr", 32'(d), 0);
    chk("irq_clr", 32'(irq), 0);
`endif

    // reset mid-burst beats a same-cycle write
    wr(8'd2, 8'd10); wr(8'd4, 8'd3); wr(8'd6, 8'd4); wr(8'd0, 8'h01);
    step();
    chk("pre_rst_pulse", 32'(pulse_out[0]), 1);
    @(negedge clk);
    rst = 1'b1; reg_addr = 8'd8; reg_wdata = 8'h01; reg_we = 1'b1;
    @(posedge clk); #1;
    reg_we = 1'b0;
    chk("mid_rst_pulse", 32'(pulse_out), 0);
    chk("mid_rst_busy",  32'(busy), 0);
    chk("mid_rst_done",  32'(done), 0);
`ifdef PPT_IRQ_EN
    chk("mid_rst_irq", 32'(irq), 0);
`endif
    rd(8'd8, d); chk("mid_rst_ctrl1", 32'(d), 0);
    rd(8'd2, d); chk("mid_rst_per0", 32'(d), 0);
    @(negedge clk); rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/multi_ppt_engine.md
MULTI_PPT_ENGINE -- requirements
Module: multi_ppt_engine

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent pulse-train channels, range 1..16.
REQ-002 Parameter CNT_W, default 16: period and width counter width in prescaled ticks, range 9..16.
REQ-003 Parameter PCNT_W, default 8: pulse-count register width.
REQ-004 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port reg_addr, input, 8: register address.
REQ-007 Port reg_wdata, input, 8: write data.
REQ-008 Port reg_we, input, 1: write strobe; one write per clk cycle while high.
REQ-009 Port reg_rdata, output, 8: combinational read of the register at reg_addr.
REQ-010 Port pulse_out, output, NUM_CH: registered per-channel pulse outputs.
REQ-011 Port busy, output, NUM_CH: channel is in ACTIVE.
REQ-012 Port done, output, NUM_CH: channel is in DONE.

Function
REQ-013 Channel c occupies addresses 8c..8c+7, with offsets: 0 CTRL {b0 run, b1 continuous, b2 polarity}; 1 DIV[4:0]; 2/3 PERIOD lo/hi; 4/5 WIDTH lo/hi; 6 COUNT; 7 STATUS (RO) {b0 busy, b1 done, b2 err}.
REQ-014 Address 0xF0 SYNC (write-only): each set bit c starts channel c on the same edge; reads return 0.
REQ-015 Unmapped or out-of-range addresses read 0, and writes to them are ignored.
REQ-016 Per-channel FSM states are IDLE, ACTIVE and DONE.
REQ-017 Start event: a CTRL write with run=1 (from any state), or a SYNC bit set while CTRL.run=1.
REQ-018 On a start event, the channel latches PERIOD, WIDTH and COUNT into shadow registers, clears the prescaler, phase counter and pulse counter, and enters ACTIVE.
REQ-019 Start latency: pulse_out shows the active level in the cycle after the write edge.
REQ-020 Prescaler: one tick every 2^DIV clk cycles, so DIV=0 gives a tick every cycle; DIV values above 15 are clamped to 15.
REQ-021 ACTIVE: the phase counter counts ticks 0..period-1 and wraps; the output is active while phase < width, and the pulse counter increments at each wrap.
REQ-022 width >= period holds the output continuously active; width = 0 gives no active level, but periods are still counted.
REQ-023 PERIOD, WIDTH and DIV writes during ACTIVE are re-latched into the shadow registers only at a period wrap, so there is never a truncated pulse.
REQ-024 Burst mode (continuous=0): after COUNT completed periods the channel enters DONE on the wrap edge.
REQ-025 A burst start with COUNT=0 goes to DONE on the next edge and emits no pulse.
REQ-026 Continuous mode: COUNT is ignored and the pulse counter wraps at 2^PCNT_W.
REQ-027 A start event with PERIOD=0 sets err, and the channel stays in IDLE.
REQ-028 err is cleared by the next valid start event.
REQ-029 Abort: a CTRL write with run=0 during ACTIVE or DONE enters IDLE on that edge, drives the inactive level next cycle, and leaves done clear.
REQ-030 pulse_out = active XOR polarity; in IDLE and DONE the output is the polarity level.
REQ-031 A CTRL write with run=1 while ACTIVE restarts the channel: shadows are reloaded and counters cleared.
REQ-032 Channels are fully independent; SYNC-started channels with equal settings produce identical edge timing.

Reset
REQ-033 While rst is high, all registers, shadows, counters and err clear to 0.
REQ-034 While rst is high, all channels are in IDLE, pulse_out/busy/done are 0, and irq is 0 where present.
REQ-035 Reset asserted mid-burst takes effect on that edge and overrides any same-cycle write.

Configuration
REQ-036 Macro PPT_IRQ_EN defined: output port irq (1 bit) and register 0xF1 IRQ_STAT are present.
REQ-037 IRQ_STAT is NUM_CH bits, write-1-to-clear; bit c sets on channel c's ACTIVE-to-DONE transition, and irq = OR of IRQ_STAT.
REQ-038 If a set and a clear of the same IRQ_STAT bit occur in one cycle, the set wins.
REQ-039 PPT_IRQ_EN undefined: no irq port, 0xF1 reads 0, and writes to 0xF1 are ignored.

Structure
REQ-040 Package ppt_pkg holds the register offsets, SYNC/IRQ_STAT addresses, CTRL/STATUS bit indices and the channel state enum.
REQ-041 Sub-module ppt_channel implements the per-channel registers, prescaler, FSM and output.
REQ-042 ppt_channel is instantiated NUM_CH times by generate; the top contains only address decode, read mux, SYNC and IRQ logic.

Verification
REQ-043 Ch0 settings DIV=0, PERIOD=10, WIDTH=3, COUNT=4, CTRL=0x01 -> 4 pulses, each 3 clk active of a 10-clk period; done after the 40th clk; busy=0.
REQ-044 Ch1 settings DIV=2, PERIOD=5, WIDTH=2, continuous -> active 8 clk of every 20 clk indefinitely; a CTRL=0x00 write drops the output next cycle, with done=0.
REQ-045 Ch0 and ch2 identical (PERIOD=6, WIDTH=1), started with SYNC=0x05 -> pulse_out[0] and pulse_out[2] are edge-aligned for every pulse.
REQ-046 Boundary settings -> WIDTH=0 gives no pulses and done after COUNT periods; WIDTH=PERIOD=7 gives a constant active level; PERIOD=0 gives err=1 with the channel staying IDLE; COUNT=0 gives done next cycle.
REQ-047 WIDTH changed 3->5 mid-period during ACTIVE -> the current pulse stays at 3 and the next pulse is 5.
REQ-048 With PPT_IRQ_EN defined, a burst completes -> IRQ_STAT bit set and irq=1; writing 0x01 to 0xF1 clears them; rst=1 mid-burst -> all outputs 0 on the next cycle.
